// File: rtl/fetch_queue.sv
// Dual-width in-order instruction queue between fetch and dual-issue decode.
// Accepts up to two {pc, instr} pairs per cycle and presents up to two to decode.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [1:0]               in_valid,
   input  logic [XLEN-1:0]          in_pc0,
   input  logic [XLEN-1:0]          in_instr0,
   input  logic [XLEN-1:0]          in_pc1,
   input  logic [XLEN-1:0]          in_instr1,
   output logic                     in_ready,
   output logic [1:0]               out_valid,
   output logic [XLEN-1:0]          out_pc0,
   output logic [XLEN-1:0]          out_instr0,
   output logic [XLEN-1:0]          out_pc1,
   output logic [XLEN-1:0]          out_instr1,
   input  logic [1:0]               deq_cnt,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Handshake: enqueue transfers popcount(in_valid) entries on an edge where
   // in_ready is high (all-or-nothing, pre-dequeue occupancy); decode takes
   // deq_cnt entries on any edge, clamped to the number presented in out_valid.

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] head_p1;
   logic [AW-1:0] tail_p1;
   logic [1:0]    enq_n;
   logic [1:0]    avail;
   logic [1:0]    deq_n;

   assign head_p1 = head + AW'(1);
   assign tail_p1 = tail + AW'(1);

   assign in_ready  = (count <= CW'(DEPTH - 2));
   assign out_valid = {(count >= CW'(2)), (count >= CW'(1))};

   assign out_pc0    = pc_mem[head];
   assign out_instr0 = instr_mem[head];
   assign out_pc1    = pc_mem[head_p1];
   assign out_instr1 = instr_mem[head_p1];

   // 2'b10 is not a legal slot pattern and is dropped like 2'b00.
   always_comb begin
      enq_n = 2'd0;
      if (in_ready) begin
         case (in_valid)
            2'b01:   enq_n = 2'd1;
            2'b11:   enq_n = 2'd2;
            default: enq_n = 2'd0;
         endcase
      end
   end

   always_comb begin
      avail = 2'd0;
      if (out_valid[1])      avail = 2'd2;
      else if (out_valid[0]) avail = 2'd1;
      deq_n = (deq_cnt > avail) ? avail : deq_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(deq_n);
         tail  <= tail + AW'(enq_n);
         count <= count + CW'(enq_n) - CW'(deq_n);
      end
   end

   // Storage carries no reset; contents are only meaningful under out_valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush && enq_n != 2'd0) begin
         pc_mem[tail]    <= in_pc0;
         instr_mem[tail] <= in_instr0;
         if (enq_n == 2'd2) begin
            pc_mem[tail_p1]    <= in_pc1;
            instr_mem[tail_p1] <= in_instr1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill, ordered drain, wrap, overlap, flush.
module tb_fetch_queue;

   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [1:0]      in_valid;
   logic [XLEN-1:0] in_pc0, in_instr0, in_pc1, in_instr1;
   logic            in_ready;
   logic [1:0]      out_valid;
   logic [XLEN-1:0] out_pc0, out_instr0, out_pc1, out_instr1;
   logic [1:0]      deq_cnt;
   logic [3:0]      count;

   int n_cmp = 0;
   int n_err = 0;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
      .in_pc0(in_pc0), .in_instr0(in_instr0), .in_pc1(in_pc1), .in_instr1(in_instr1),
      .in_ready(in_ready), .out_valid(out_valid),
      .out_pc0(out_pc0), .out_instr0(out_instr0), .out_pc1(out_pc1), .out_instr1(out_instr1),
      .deq_cnt(deq_cnt), .count(count)
   );

   always #5 clk = ~clk;

   // Protocol rules fetch and decode must obey.
   always @(posedge clk) begin
      if (!rst) begin
         assert (in_valid != 2'b10) else $error("illegal in_valid 2'b10");
         assert (deq_cnt <= {1'b0, out_valid[1]} + {1'b0, out_valid[0]})
            else $error("deq_cnt %0d exceeds presented entries %b", deq_cnt, out_valid);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_enq(input logic [1:0] v, input logic [XLEN-1:0] pc);
      in_valid  = v;
      in_pc0    = pc;
      in_instr0 = ~pc;
      in_pc1    = pc + 32'd4;
      in_instr1 = ~(pc + 32'd4);
   endtask

   task automatic idle;
      in_valid = 2'b00;
      deq_cnt  = 2'd0;
      flush    = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle();
      drive_enq(2'b11, 32'hDEAD_0000);
      tick();
      tick();
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
      n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL reset_out_valid got %b exp 00", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      rst = 1'b0;
      idle();
      tick();
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_no_enq got %0d exp 0", count); end
   endtask

   task automatic test_fill;
      for (int k = 0; k < 4; k++) begin
         drive_enq(2'b11, 32'(k * 8));
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d] got %b exp 1", k, in_ready); end
         tick();
         n_cmp++; if (count !== 4'(2 * k + 2)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, count, 2 * k + 2); end
      end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b exp 0", in_ready); end
      drive_enq(2'b11, 32'h20);
      tick();
      idle();
      #1;
      n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL full_no_write got %0d exp 8", count); end
      n_cmp++; if (out_pc0 !== 32'h0) begin n_err++; $display("FAIL full_head_pc got %h exp 0", out_pc0); end
   endtask

   task automatic test_drain;
      logic [XLEN-1:0] e0, e1;
      for (int k = 0; k < 4; k++) begin
         e0 = 32'(k * 8);
         e1 = e0 + 32'd4;
         deq_cnt = 2'd2;
         #1;
         n_cmp++; if (out_valid !== 2'b11) begin n_err++; $display("FAIL drain_valid[%0d] got %b exp 11", k, out_valid); end
         n_cmp++; if (out_pc0 !== e0 || out_instr0 !== ~e0) begin n_err++; $display("FAIL drain_slot0[%0d] got %h/%h exp %h/%h", k, out_pc0, out_instr0, e0, ~e0); end
         n_cmp++; if (out_pc1 !== e1 || out_instr1 !== ~e1) begin n_err++; $display("FAIL drain_slot1[%0d] got %h/%h exp %h/%h", k, out_pc1, out_instr1, e1, ~e1); end
         tick();
      end
      idle();
      #1;
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL drain_count got %0d exp 0", count); end
      n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL drain_valid_end got %b exp 00", out_valid); end
   endtask

   // head=tail=0 on entry; ends with entries 0x218/0x21C/0x220 at indices 6, 7, 0.
   task automatic test_wrap;
      logic [XLEN-1:0] e0;
      drive_enq(2'b01, 32'h200); tick();
      n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL wrap_odd_count got %0d exp 1", count); end
      for (int k = 0; k < 3; k++) begin
         drive_enq(2'b11, 32'h204 + 32'(k * 8)); tick();
         n_cmp++; if (count !== 4'(3 + 2 * k)) begin n_err++; $display("FAIL wrap_enq_count[%0d] got %0d exp %0d", k, count, 3 + 2 * k); end
      end
      idle();
      for (int k = 0; k < 6; k++) begin
         e0 = 32'h200 + 32'(k * 4);
         deq_cnt = 2'd1;
         #1;
         n_cmp++; if (out_pc0 !== e0) begin n_err++; $display("FAIL wrap_deq_pc[%0d] got %h exp %h", k, out_pc0, e0); end
         tick();
         n_cmp++; if (count !== 4'(6 - k)) begin n_err++; $display("FAIL wrap_deq_count[%0d] got %0d exp %0d", k, count, 6 - k); end
      end
      idle();
      drive_enq(2'b11, 32'h21C); tick();
      idle();
      #1;
      n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL wrap_refill_count got %0d exp 3", count); end
      for (int k = 0; k < 3; k++) begin
         e0 = 32'h218 + 32'(k * 4);
         deq_cnt = 2'd1;
         #1;
         n_cmp++; if (out_pc0 !== e0 || out_instr0 !== ~e0) begin n_err++; $display("FAIL wrap_out0[%0d] got %h exp %h", k, out_pc0, e0); end
         if (k < 2) begin
            n_cmp++; if (out_pc1 !== e0 + 32'd4 || out_valid !== 2'b11) begin n_err++; $display("FAIL wrap_out1[%0d] got %h v=%b exp %h v=11", k, out_pc1, out_valid, e0 + 32'd4); end
         end else begin
            n_cmp++; if (out_valid !== 2'b01) begin n_err++; $display("FAIL wrap_last_valid got %b exp 01", out_valid); end
         end
         tick();
         n_cmp++; if (count !== 4'(2 - k)) begin n_err++; $display("FAIL wrap_drain_count[%0d] got %0d exp %0d", k, count, 2 - k); end
      end
      idle();
   endtask

   task automatic test_simultaneous;
      for (int k = 0; k < 3; k++) begin
         drive_enq(2'b11, 32'h300 + 32'(k * 8)); tick();
      end
      idle();
      #1;
      n_cmp++; if (count !== 4'd6) begin n_err++; $display("FAIL sim_pre_count got %0d exp 6", count); end
      drive_enq(2'b11, 32'h318);
      deq_cnt = 2'd2;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sim6_ready got %b exp 1", in_ready); end
      tick();
      n_cmp++; if (count !== 4'd6) begin n_err++; $display("FAIL sim6_count got %0d exp 6", count); end
      n_cmp++; if (out_pc0 !== 32'h308) begin n_err++; $display("FAIL sim6_head got %h exp 308", out_pc0); end
      deq_cnt = 2'd0;
      drive_enq(2'b01, 32'h320); tick();
      n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL sim_to7_count got %0d exp 7", count); end
      drive_enq(2'b11, 32'h324);
      deq_cnt = 2'd2;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sim7_ready got %b exp 0", in_ready); end
      tick();
      idle();
      #1;
      n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL sim7_count got %0d exp 5", count); end
      n_cmp++; if (out_pc0 !== 32'h310 || out_pc1 !== 32'h314) begin n_err++; $display("FAIL sim7_head got %h/%h exp 310/314", out_pc0, out_pc1); end
   endtask

   task automatic test_flush;
      flush = 1'b1;
      drive_enq(2'b11, 32'h400);
      deq_cnt = 2'd1;
      tick();
      idle();
      #1;
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", count); end
      n_cmp++; if (out_valid !== 2'b00) begin n_err++; $display("FAIL flush_valid got %b exp 00", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b exp 1", in_ready); end
      drive_enq(2'b01, 32'h100); tick();
      idle();
      #1;
      n_cmp++; if (out_pc0 !== 32'h100 || out_instr0 !== ~32'h100) begin n_err++; $display("FAIL flush_refill_pc got %h/%h exp 100/%h", out_pc0, out_instr0, ~32'h100); end
      n_cmp++; if (out_valid !== 2'b01 || count !== 4'd1) begin n_err++; $display("FAIL flush_refill_state got v=%b c=%0d exp v=01 c=1", out_valid, count); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      drive_enq(2'b00, 32'h0);
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
